// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit CPU: owns PC, IR, Z/C flags and the ALU.
// Optional feature macro: CPU_SINGLE_STEP_EN (adds a `step` input gating each instruction fetch).
module cpu_control_fsm #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic [1:0]        rf_read_reg1,
  output logic [1:0]        rf_read_reg2,
  input  logic [7:0]        rf_read_data1,
  input  logic [7:0]        rf_read_data2,
  output logic [1:0]        rf_write_reg,
  output logic [7:0]        rf_write_data,
  output logic              rf_reg_write,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted,
  output logic              illegal_op,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [7:0]        ir, ir_nxt;
  logic [7:0]        imm, imm_nxt;
  logic              z_nxt, c_nxt;
  logic              fetch_go;
  logic              hs;
  logic [3:0]        opcode;
  logic [8:0]        sum9, diff9;

`ifdef CPU_SINGLE_STEP_EN
  logic step_seen;

  // One step pulse arms exactly one fetch; the latch is consumed by the following EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_seen <= 1'b0;
    end else if (state == S_EXEC) begin
      step_seen <= 1'b0;
    end else if (step) begin
      step_seen <= 1'b1;
    end
  end

  assign fetch_go = step_seen;
`else
  assign fetch_go = 1'b1;
`endif

  // Gated with rst_n so no request escapes while reset is held.
  assign imem_req  = rst_n && ((state == S_FETCH && fetch_go) || state == S_OPERAND);
  assign imem_addr = pc;
  assign hs        = imem_req && imem_ack;

  assign opcode       = ir[7:4];
  assign rf_read_reg1 = ir[3:2];
  assign rf_read_reg2 = ir[1:0];
  assign rf_write_reg = ir[3:2];
  assign halted       = (state == S_HALT);

  assign sum9  = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
  assign diff9 = {1'b0, rf_read_data1} - {1'b0, rf_read_data2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= ADDR_W'(RESET_PC);
      ir         <= '0;
      imm        <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ir         <= ir_nxt;
      imm        <= imm_nxt;
      zero_flag  <= z_nxt;
      carry_flag <= c_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    imm_nxt       = imm;
    z_nxt         = zero_flag;
    c_nxt         = carry_flag;
    rf_reg_write  = 1'b0;
    rf_write_data = '0;
    illegal_op    = 1'b0;

    case (state)
      S_FETCH: begin
        if (hs) begin
          ir_nxt    = imem_data;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          4'h7, 4'h8, 4'h9: state_nxt = S_OPERAND;
          4'hF:             state_nxt = S_HALT;
          default:          state_nxt = S_EXEC;
        endcase
      end

      S_OPERAND: begin
        if (hs) begin
          imm_nxt   = imem_data;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          4'h0: ;
          4'h1: begin
            rf_reg_write  = 1'b1;
            rf_write_data = sum9[7:0];
            c_nxt         = sum9[8];
            z_nxt         = (sum9[7:0] == 8'h00);
          end
          4'h2: begin
            // Bit 8 of the zero-extended difference is the borrow (data1 < data2).
            rf_reg_write  = 1'b1;
            rf_write_data = diff9[7:0];
            c_nxt         = diff9[8];
            z_nxt         = (diff9[7:0] == 8'h00);
          end
          4'h3: begin
            rf_reg_write  = 1'b1;
            rf_write_data = rf_read_data1 & rf_read_data2;
            c_nxt         = 1'b0;
            z_nxt         = ((rf_read_data1 & rf_read_data2) == 8'h00);
          end
          4'h4: begin
            rf_reg_write  = 1'b1;
            rf_write_data = rf_read_data1 | rf_read_data2;
            c_nxt         = 1'b0;
            z_nxt         = ((rf_read_data1 | rf_read_data2) == 8'h00);
          end
          4'h5: begin
            rf_reg_write  = 1'b1;
            rf_write_data = rf_read_data1 ^ rf_read_data2;
            c_nxt         = 1'b0;
            z_nxt         = ((rf_read_data1 ^ rf_read_data2) == 8'h00);
          end
          4'h6: begin
            rf_reg_write  = 1'b1;
            rf_write_data = rf_read_data2;
          end
          4'h7: begin
            rf_reg_write  = 1'b1;
            rf_write_data = imm;
          end
          4'h8: pc_nxt = ADDR_W'(imm);
          4'h9: begin
            if (zero_flag) pc_nxt = ADDR_W'(imm);
          end
          default: illegal_op = 1'b1;
        endcase
      end

      S_HALT: state_nxt = S_HALT;

      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: stimulus queues expected register writes / illegal pulses,
// a monitor pops and compares them whenever the DUT strobes a write or an illegal-op pulse.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [7:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic       rf_reg_write, zero_flag, carry_flag, halted, illegal_op;
  logic [7:0] pc;
`ifdef CPU_SINGLE_STEP_EN
  logic       step;
`endif

  logic       ack_en;
  logic [7:0] mem [256];
  logic [7:0] rf [4];
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         kind;   // 0 = register write, 1 = illegal-op pulse
    logic [1:0] rd;
    logic [7:0] data;
    logic       z;
    logic       c;
    logic [7:0] pcv;
    int         cyc;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;

  cpu_control_fsm #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef CPU_SINGLE_STEP_EN
    .step         (step),
`endif
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .rf_read_reg1 (rf_read_reg1),
    .rf_read_reg2 (rf_read_reg2),
    .rf_read_data1(rf_read_data1),
    .rf_read_data2(rf_read_data2),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data),
    .rf_reg_write (rf_reg_write),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .halted       (halted),
    .illegal_op   (illegal_op),
    .pc           (pc)
  );

  assign imem_ack      = ack_en;
  assign imem_data     = mem[imem_addr];
  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (rf_reg_write) begin
      rf[rf_write_reg] <= rf_write_data;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_w(input logic [1:0] rd, input logic [7:0] data, input logic z, input logic c,
                        input int ecyc);
    ev_t e;
    e.kind = 0; e.rd = rd; e.data = data; e.z = z; e.c = c; e.pcv = 8'h00; e.cyc = ecyc;
    sb.push_back(e);
  endtask

  task automatic push_ill(input logic [7:0] pcv);
    ev_t e;
    e.kind = 1; e.rd = 2'd0; e.data = 8'h00; e.z = 1'b0; e.c = 1'b0; e.pcv = pcv; e.cyc = -1;
    sb.push_back(e);
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 500 && !halted; i++) @(negedge clk);
    chk(name, halted, 1'b1);
  endtask

  // Monitor: every write strobe or illegal pulse must match the head of the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (rf_reg_write === 1'b1 || illegal_op === 1'b1)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: write=%0b reg=%0d data=%0h illegal=%0b, expected none",
                   rf_reg_write, rf_write_reg, rf_write_data, illegal_op);
        end else begin
          e = sb.pop_front();
          if (e.kind == 0) begin
            chk("write_strobe", rf_reg_write, 1'b1);
            chk("write_reg", rf_write_reg, e.rd);
            chk("write_data", rf_write_data, e.data);
            chk("write_not_illegal", illegal_op, 1'b0);
            if (e.cyc >= 0) chk("exec_cycle", cyc, e.cyc);
            @(posedge clk); #1;
            chk("zero_flag", zero_flag, e.z);
            chk("carry_flag", carry_flag, e.c);
          end else begin
            chk("illegal_pulse", illegal_op, 1'b1);
            chk("illegal_no_write", rf_reg_write, 1'b0);
            chk("illegal_pc", pc, e.pcv);
            @(posedge clk); #1;
            chk("illegal_one_cycle", illegal_op, 1'b0);
          end
        end
      end
    end
  end

  initial begin
    bit         found;
    logic [7:0] exp_addr;
    rst_n  = 1'b0;
    ack_en = 1'b1;
`ifdef CPU_SINGLE_STEP_EN
    step   = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;

    // Program A: LDI/ADD, SUB+JZ, ADD/SUB carry cases, illegal opcode, halt.
    mem[8'h00] = 8'h74; mem[8'h01] = 8'h05;
    mem[8'h02] = 8'h78; mem[8'h03] = 8'h03;
    mem[8'h04] = 8'h16;
    mem[8'h05] = 8'h74; mem[8'h06] = 8'h07;
    mem[8'h07] = 8'h78; mem[8'h08] = 8'h07;
    mem[8'h09] = 8'h26;
    mem[8'h0A] = 8'h90; mem[8'h0B] = 8'h20;
    mem[8'h20] = 8'h74; mem[8'h21] = 8'hFF;
    mem[8'h22] = 8'h78; mem[8'h23] = 8'h01;
    mem[8'h24] = 8'h16;
    mem[8'h25] = 8'h26;
    mem[8'h26] = 8'hA0;
    mem[8'h27] = 8'hF0;

    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_write", rf_reg_write, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_zero", zero_flag, 1'b0);
    chk("rst_carry", carry_flag, 1'b0);
    chk("rst_read_reg1", rf_read_reg1, 2'd0);

    push_w(2'd1, 8'h05, 1'b0, 1'b0, -1);
    push_w(2'd2, 8'h03, 1'b0, 1'b0, -1);
    push_w(2'd1, 8'h08, 1'b0, 1'b0, 10);
    push_w(2'd1, 8'h07, 1'b0, 1'b0, -1);
    push_w(2'd2, 8'h07, 1'b0, 1'b0, -1);
    push_w(2'd1, 8'h00, 1'b1, 1'b0, -1);
    push_w(2'd1, 8'hFF, 1'b1, 1'b0, -1);
    push_w(2'd2, 8'h01, 1'b1, 1'b0, -1);
    push_w(2'd1, 8'h00, 1'b1, 1'b1, -1);
    push_w(2'd1, 8'hFF, 1'b0, 1'b1, -1);
    push_ill(8'h27);
    rst_n = 1'b1;

    wait_halt("halt_reached_a");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_hold", halted, 1'b1);
      chk("halt_no_req", imem_req, 1'b0);
    end
    chk("sb_drained_a", sb.size(), 0);
    chk("halt_pc", pc, 8'h28);

    // Program B: JMP to 0xFF, NOP there, PC must wrap to 0x00.
    rst_n = 1'b0;
    mem[8'h00] = 8'h80; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_ack && imem_addr == 8'hFF) found = 1'b1;
    end
    chk("wrap_fetch_ff", found, 1'b1);
    mem[8'h00] = 8'hF0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req) found = 1'b1;
    end
    chk("wrap_next_req", found, 1'b1);
    chk("wrap_addr", imem_addr, 8'h00);
    wait_halt("halt_reached_b");

    // Program C: fetch stalled by ack=0, then reset mid-stall abandons it.
    rst_n = 1'b0;
    mem[8'h00] = 8'h00; mem[8'h01] = 8'h00; mem[8'h02] = 8'hF0;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 8'h01) found = 1'b1;
    end
    chk("stall_reach_fetch1", found, 1'b1);
    ack_en   = 1'b0;
    exp_addr = 8'h01;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, exp_addr);
      chk("stall_no_write", rf_reg_write, 1'b0);
      if (i == 1) begin
        #2 rst_n = 1'b0;
        #1;
        chk("stall_rst_pc", pc, 8'h00);
        chk("stall_rst_req", imem_req, 1'b0);
        #1 rst_n = 1'b1;
        exp_addr = 8'h00;
      end
    end
    ack_en = 1'b1;
    wait_halt("halt_reached_c");
    chk("halt_pc_c", pc, 8'h03);

`ifdef CPU_SINGLE_STEP_EN
    // Program D: nothing is fetched until a step pulse; one pulse runs one instruction.
    rst_n = 1'b0;
    mem[8'h00] = 8'h74; mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h78; mem[8'h03] = 8'h22;
    mem[8'h04] = 8'hF0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("step_idle_no_req", imem_req, 1'b0);
    end
    push_w(2'd1, 8'h11, 1'b0, 1'b0, -1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
    chk("step_one_instr_pc", pc, 8'h02);
    chk("step_after_no_req", imem_req, 1'b0);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
